data_mem_access_unit: RTL and testbench
=======================================

Name: data_mem_access_unit

Overview:
- Executes the memory side of the control decode: consumes MemRead/MemWrite plus funct3 and drives a valid/ready data-memory bus.
- Handles byte-lane strobes for stores, alignment/extension for loads, misalignment detection, and a bus timeout.
- Sits between the ALU result (address) / rs2 data and data memory; stalls the core while a transaction is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, max cycles mem_valid may stay high without mem_ready before a fault is raised (1..65535)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
mem_read  in  1  load request (control MemRead)
mem_write  in  1  store request (control MemWrite)
funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
addr  in  32  byte address (ALU result)
wdata  in  32  store data (rs2)
stall  out  1  core must hold current instruction
done  out  1  one-cycle pulse: access completed
rdata  out  32  extended load result, valid when done=1 and the op was a load
fault  out  1  one-cycle pulse: misaligned, illegal funct3, or timeout
bus_valid  out  1  request valid
bus_we  out  1  1 = write
bus_addr  out  32  word address ({addr[31:2],2'b00})
bus_wstrb  out  4  byte enables (0 on reads)
bus_wdata  out  32  lane-replicated store data
bus_ready  in  1  memory accepts/completes request
bus_rdata  in  32  read word, valid with bus_ready

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0, including bus_valid, which drops in the same instant; timeout counter 0.
- States: IDLE, BUS, RESP.
- IDLE, no request: stall=0, done=0.
- IDLE, request present (mem_write has priority if both are high, and is treated as a store only):
  - Legal funct3 is 000/001/010/100/101 for loads and 000/001/010 for stores.
  - Illegal funct3, or misaligned access (half with addr[0]=1; word with addr[1:0]!=0): fault=1 this cycle, stall=0, no bus activity, stay in IDLE.
  - Otherwise: stall=1 combinationally. Next edge latches addr[1:0], funct3, direction, word address, strobe and data, then moves to BUS.
- BUS:
  - bus_valid=1; bus fields held stable; stall=1.
  - Counter increments each cycle without bus_ready.
  - bus_ready=1: capture bus_rdata, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 with no ready: fault pulse on the next cycle (in IDLE), bus_valid drops, return to IDLE, stall released.
  - bus_ready and timeout in the same cycle: ready wins.
- RESP:
  - done=1, stall=0, rdata valid; unconditionally back to IDLE.
  - Requests seen in RESP are ignored, because they are the same instruction still presented.
- Store strobes:
  - sb: 0001<<addr[1:0]; sh: 0011<<addr[1:0]; sw: 1111.
  - bus_wdata: sb replicates wdata[7:0] x4; sh replicates wdata[15:0] x2; sw uses wdata as-is.
- Load extraction:
  - Byte = rdata_word[8*off +: 8]; half = rdata_word[16*off[1] +: 16].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw unchanged.
  - rdata is 0 after stores and whenever done=0.
- Latency: aligned access with bus_ready on the first BUS cycle gives request -> done in 2 cycles (IDLE->BUS->RESP).
- Counter width: $clog2(TIMEOUT_CYCLES+1); cleared on entry to BUS.

Decomposition:
- Shared package (riscv_pkg): funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state enum typedef (IDLE/BUS/RESP).
- One combinational sub-module, load_align: inputs funct3, offset[1:0] and word; output is the 32-bit extended result.

Test Plan:
- Aligned store: sw addr=0x100, wdata=0xDEADBEEF, bus_ready on first BUS cycle -> bus_addr=0x100, wstrb=1111, wdata=0xDEADBEEF, we=1; done 2 cycles after request; stall high 2 cycles.
- Byte store/load: sb addr=0x103, wdata=0x000000A5 -> wstrb=1000, bus_wdata=0xA5A5A5A5. Then lb addr=0x103 with bus_rdata=0xA5000000 -> rdata=0xFFFFFFA5; lbu -> 0x000000A5.
- Half load: lh addr=0x102, bus_rdata=0x80010000 -> rdata=0xFFFF8001; lhu -> 0x00008001.
- Misaligned/illegal: lw addr=0x101 -> fault=1 same cycle, bus_valid never rises, stall=0. Load funct3=011 -> fault. Store funct3=100 -> fault.
- Wait states and timeout:
  - bus_ready delayed 5 cycles -> bus fields stable throughout, done on cycle 7.
  - TIMEOUT_CYCLES=4 with ready never asserted -> exactly 4 BUS cycles, then fault pulse, stall drops.
- Async reset mid-BUS: assert rst between edges -> bus_valid, stall, done, fault drop immediately. After release, a new lw completes normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared load/store definitions for the data-memory access path.
// Funct3 encodings, FSM states and store lane helpers.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    function automatic logic f3_legal(input logic is_st, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_st;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (f3[1:0])
            2'b01:   bad = off[0];
            2'b10:   bad = (off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] s;
        s = 4'b0000;
        case (f3[1:0])
            2'b00:   s = 4'b0001 << off;
            2'b01:   s = 4'b0011 << off;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        d = wd;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/data_mem_access_unit_load_align.sv
// Load lane extraction and sign/zero extension of a memory read word.
// Purely combinational; unknown funct3 yields zero.
module load_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{offset, 3'b000} +: 8];
    assign half_sel = word[{offset[1], 4'b0000} +: 16];

    always_comb begin
        ext = '0;
        case (funct3)
            F3_B:    ext = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ext = {24'h0, byte_sel};
            F3_H:    ext = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ext = {16'h0, half_sel};
            F3_W:    ext = word;
            default: ext = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_access_unit.sv
// Data-memory access unit: turns MemRead/MemWrite into a valid/ready bus
// transaction with lane strobes, load extension, misalign and timeout faults.
module data_mem_access_unit
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    mem_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  strb_q, strb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        tmo_q, tmo_d;

    logic        req;
    logic        is_st;
    logic [31:0] ext;

    // Requests are masked during reset so stall/fault fall with it.
    assign req   = (mem_read | mem_write) & ~rst;
    assign is_st = mem_write;

    load_align u_align (
        .funct3 (f3_q),
        .offset (off_q),
        .word   (rdata_q),
        .ext    (ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            strb_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            strb_q  <= strb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        f3_d    = f3_q;
        we_d    = we_q;
        addr_d  = addr_q;
        strb_d  = strb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        tmo_d   = 1'b0;
        stall   = 1'b0;
        done    = 1'b0;
        rdata   = '0;
        fault   = tmo_q;

        case (state_q)
            IDLE: begin
                // The timed-out instruction retires on the fault cycle.
                if (req && !tmo_q) begin
                    if (!f3_legal(is_st, funct3) || misaligned(funct3, addr[1:0])) begin
                        fault = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = BUS;
                        cnt_d   = '0;
                        off_d   = addr[1:0];
                        f3_d    = funct3;
                        we_d    = is_st;
                        addr_d  = {addr[31:2], 2'b00};
                        strb_d  = is_st ? store_strb(funct3, addr[1:0]) : 4'b0000;
                        wdata_d = is_st ? store_data(funct3, wdata) : 32'h0;
                    end
                end
            end
            BUS: begin
                stall = 1'b1;
                if (bus_ready) begin
                    rdata_d = bus_rdata;
                    state_d = RESP;
                end else if (cnt_q == TO_LAST) begin
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                done    = 1'b1;
                rdata   = we_q ? 32'h0 : ext;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus_valid = (state_q == BUS);
    assign bus_we    = bus_valid & we_q;
    assign bus_addr  = bus_valid ? addr_q : 32'h0;
    assign bus_wstrb = bus_valid ? strb_q : 4'b0000;
    assign bus_wdata = bus_valid ? wdata_q : 32'h0;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed vector bench for data_mem_access_unit, plus timeout and
// asynchronous-reset sequences on a short-timeout second instance.
module tb_data_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, done, fault;
    logic [31:0] rdata;
    logic        bus_valid, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    logic        rd2, wr2, rdy2;
    logic        stall2, done2, fault2;
    logic [31:0] rdata2;
    logic        bus_valid2, bus_we2;
    logic [31:0] bus_addr2, bus_wdata2;
    logic [3:0]  bus_wstrb2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_mem_access_unit #(.TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .rdata(rdata), .fault(fault),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    data_mem_access_unit #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst(rst),
        .mem_read(rd2), .mem_write(wr2),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .stall(stall2), .done(done2), .rdata(rdata2), .fault(fault2),
        .bus_valid(bus_valid2), .bus_we(bus_we2), .bus_addr(bus_addr2),
        .bus_wstrb(bus_wstrb2), .bus_wdata(bus_wdata2),
        .bus_ready(rdy2), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        int          dly;
        logic [31:0] brd;
        logic        ef;
        logic [3:0]  es;
        logic [31:0] ew;
        logic [31:0] er;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string p;
        p = $sformatf("v%0d", idx);
        @(negedge clk);
        mem_read  = v.rd;
        mem_write = v.wr;
        funct3    = v.f3;
        addr      = v.a;
        wdata     = v.wd;
        bus_ready = 1'b0;
        #1;
        if (v.ef) begin
            chk({p, " fault"}, 32'(fault), 32'd1);
            chk({p, " stall"}, 32'(stall), 32'd0);
            chk({p, " valid"}, 32'(bus_valid), 32'd0);
            @(negedge clk);
            chk({p, " valid+1"}, 32'(bus_valid), 32'd0);
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end else begin
            chk({p, " stall0"}, 32'(stall), 32'd1);
            for (int k = 1; k <= v.dly + 1; k++) begin
                @(negedge clk);
                chk({p, " valid"}, 32'(bus_valid), 32'd1);
                chk({p, " bstall"}, 32'(stall), 32'd1);
                chk({p, " we"}, 32'(bus_we), 32'(v.wr));
                chk({p, " baddr"}, bus_addr, v.a & 32'hFFFF_FFFC);
                chk({p, " strb"}, 32'(bus_wstrb), 32'(v.es));
                chk({p, " bwdata"}, bus_wdata, v.ew);
                if (k == v.dly + 1) begin
                    bus_ready = 1'b1;
                    bus_rdata = v.brd;
                end
            end
            @(negedge clk);
            bus_ready = 1'b0;
            bus_rdata = 32'h0;
            #1;
            chk({p, " done"}, 32'(done), 32'd1);
            chk({p, " rstall"}, 32'(stall), 32'd0);
            chk({p, " rvalid"}, 32'(bus_valid), 32'd0);
            chk({p, " rdata"}, rdata, v.er);
            mem_read  = 1'b0;
            mem_write = 1'b0;
            @(negedge clk);
            chk({p, " done+1"}, 32'(done), 32'd0);
            chk({p, " rdata+1"}, rdata, 32'h0);
        end
    endtask

    initial begin
        int n;
        vec_t v;
        rst = 1'b1;
        mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; wdata = 0;
        bus_ready = 0; bus_rdata = 0;
        rd2 = 0; wr2 = 0; rdy2 = 0;

        //          rd wr f3      addr          wdata         dly brd           ef es       ew            er
        vt.push_back('{0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0,        0, 4'b1111, 32'hDEADBEEF, 32'h0});
        vt.push_back('{0, 1, 3'b000, 32'h103, 32'h000000A5, 0, 32'h0,        0, 4'b1000, 32'hA5A5A5A5, 32'h0});
        vt.push_back('{1, 0, 3'b000, 32'h103, 32'h0,        0, 32'hA5000000, 0, 4'b0000, 32'h0,        32'hFFFFFFA5});
        vt.push_back('{1, 0, 3'b100, 32'h103, 32'h0,        0, 32'hA5000000, 0, 4'b0000, 32'h0,        32'h000000A5});
        vt.push_back('{1, 0, 3'b001, 32'h102, 32'h0,        0, 32'h80010000, 0, 4'b0000, 32'h0,        32'hFFFF8001});
        vt.push_back('{1, 0, 3'b101, 32'h102, 32'h0,        0, 32'h80010000, 0, 4'b0000, 32'h0,        32'h00008001});
        vt.push_back('{1, 0, 3'b010, 32'h101, 32'h0,        0, 32'h0,        1, 4'b0000, 32'h0,        32'h0});
        vt.push_back('{1, 0, 3'b011, 32'h100, 32'h0,        0, 32'h0,        1, 4'b0000, 32'h0,        32'h0});
        vt.push_back('{0, 1, 3'b100, 32'h100, 32'h0,        0, 32'h0,        1, 4'b0000, 32'h0,        32'h0});
        vt.push_back('{1, 0, 3'b010, 32'h200, 32'h0,        5, 32'h12345678, 0, 4'b0000, 32'h0,        32'h12345678});
        vt.push_back('{0, 1, 3'b001, 32'h206, 32'h0000BEEF, 0, 32'h0,        0, 4'b1100, 32'hBEEFBEEF, 32'h0});
        vt.push_back('{1, 1, 3'b010, 32'h300, 32'h11223344, 0, 32'h55667788, 0, 4'b1111, 32'h11223344, 32'h0});
        vt.push_back('{1, 0, 3'b000, 32'h101, 32'h0,        1, 32'h00007F00, 0, 4'b0000, 32'h0,        32'h0000007F});
        vt.push_back('{0, 1, 3'b010, 32'h102, 32'h0,        0, 32'h0,        1, 4'b0000, 32'h0,        32'h0});
        vt.push_back('{1, 0, 3'b001, 32'h103, 32'h0,        0, 32'h0,        1, 4'b0000, 32'h0,        32'h0});

        repeat (2) @(negedge clk);
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst fault", 32'(fault), 32'd0);
        chk("rst valid", 32'(bus_valid), 32'd0);
        chk("rst rdata", rdata, 32'h0);
        chk("rst strb", 32'(bus_wstrb), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            run_vec(vt[i], i);
        end

        // Timeout on the 4-cycle instance, request held through the fault.
        @(negedge clk);
        funct3 = 3'b010;
        addr   = 32'h400;
        rd2    = 1'b1;
        #1;
        chk("to stall0", 32'(stall2), 32'd1);
        n = 0;
        @(negedge clk);
        while (bus_valid2 && n < 20) begin
            chk("to bstall", 32'(stall2), 32'd1);
            chk("to nofault", 32'(fault2), 32'd0);
            n++;
            @(negedge clk);
        end
        chk("to buscycles", 32'(n), 32'd4);
        chk("to fault", 32'(fault2), 32'd1);
        chk("to stall", 32'(stall2), 32'd0);
        chk("to valid", 32'(bus_valid2), 32'd0);
        rd2 = 1'b0;
        @(negedge clk);
        chk("to fault+1", 32'(fault2), 32'd0);
        chk("to done", 32'(done2), 32'd0);

        // Asynchronous reset while a load waits on the bus.
        @(negedge clk);
        mem_read = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h500;
        @(negedge clk);
        chk("ar valid pre", 32'(bus_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar valid", 32'(bus_valid), 32'd0);
        chk("ar stall", 32'(stall), 32'd0);
        chk("ar done", 32'(done), 32'd0);
        chk("ar fault", 32'(fault), 32'd0);
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        v = '{1, 0, 3'b010, 32'h504, 32'h0, 0, 32'hCAFEF00D, 0, 4'b0000, 32'h0, 32'hCAFEF00D};
        run_vec(v, 99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
